// File: rtl/audio_decoder.sv
// audio_decoder: serial-to-parallel receiver for the audio_encoder bit stream.
// A toggle on audio_ws marks the MSB of a new word (no one-bit I2S delay).
// Each complete WORD_WIDTH-bit word is presented with its channel and a
// one-cycle strobe; a ws toggle that cuts a word short raises frame_err.
module audio_decoder #(
    parameter int WORD_WIDTH = 8,
    parameter int VOL_WIDTH  = 6
) (
    input  logic                  clk_audio_bit,
    input  logic                  reset_n,
    input  logic                  audio_data,
    input  logic                  audio_ws,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_ch,
    output logic                  word_valid,
    output logic [VOL_WIDTH-1:0]  vol,
    output logic                  frame_err
);

    // Counter only advances inside RECV, so one extra bit is ample headroom.
    localparam int CNT_W = $clog2(WORD_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        RECV = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                state_q;
    logic                  ws_q;
    logic                  ch_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  word_ch_q;
    logic                  word_valid_q;
    logic [VOL_WIDTH-1:0]  vol_q;
    logic                  frame_err_q;

    logic                  ws_edge;
    logic [WORD_WIDTH-1:0] word_d;

    assign ws_edge = (audio_ws != ws_q);
    // The completed word: the MSBs already shifted in plus the current LSB.
    assign word_d  = {shift_q[WORD_WIDTH-2:0], audio_data};

    // Receive FSM: hunts for a ws toggle, shifts in one word, then idles until the next toggle.
    always_ff @(posedge clk_audio_bit or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= HUNT;
            ws_q         <= 1'b0;
            ch_q         <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_ch_q    <= 1'b0;
            word_valid_q <= 1'b0;
            vol_q        <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            ws_q         <= audio_ws;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                HUNT, WAIT: begin
                    // Extra slot bits in WAIT and pre-sync bits in HUNT are ignored.
                    if (ws_edge) begin
                        shift_q <= {{(WORD_WIDTH-1){1'b0}}, audio_data};
                        cnt_q   <= CNT_W'(1);
                        ch_q    <= audio_ws;
                        state_q <= RECV;
                    end
                end
                RECV: begin
                    if (ws_edge) begin
                        // Short word: drop it and restart on the current bit.
                        frame_err_q <= 1'b1;
                        shift_q     <= {{(WORD_WIDTH-1){1'b0}}, audio_data};
                        cnt_q       <= CNT_W'(1);
                        ch_q        <= audio_ws;
                    end else begin
                        shift_q <= word_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            word_q       <= word_d;
                            word_ch_q    <= ch_q;
                            vol_q        <= word_d[VOL_WIDTH-1:0];
                            word_valid_q <= 1'b1;
                            state_q      <= WAIT;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign word       = word_q;
    assign word_ch    = word_ch_q;
    assign word_valid = word_valid_q;
    assign vol        = vol_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_audio_decoder.sv
// tb_audio_decoder: slot-level reference model for audio_decoder.
// Stimulus is a sequence of ws slots (one ws level, some number of bits).
// A slot of >= 8 bits yields a word strobe on its 8th bit; a slot shorter
// than 8 bits yields frame_err on the first bit of the following slot.
module tb_audio_decoder;

    localparam int WW = 8;
    localparam int VW = 6;

    logic          clk_audio_bit = 1'b0;
    logic          reset_n       = 1'b0;
    logic          audio_data    = 1'b0;
    logic          audio_ws      = 1'b0;
    logic [WW-1:0] word;
    logic          word_ch;
    logic          word_valid;
    logic [VW-1:0] vol;
    logic          frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [WW-1:0] m_word;
    logic          m_ch;
    logic          cur_ws;
    int            prev_len;

    audio_decoder #(.WORD_WIDTH(WW), .VOL_WIDTH(VW)) dut (
        .clk_audio_bit(clk_audio_bit),
        .reset_n      (reset_n),
        .audio_data   (audio_data),
        .audio_ws     (audio_ws),
        .word         (word),
        .word_ch      (word_ch),
        .word_valid   (word_valid),
        .vol          (vol),
        .frame_err    (frame_err)
    );

    always #5 clk_audio_bit = ~clk_audio_bit;

    typedef struct {
        logic          ws;
        int            len;
        logic [WW-1:0] d;
        logic          junk;
        logic          exp_err;
        logic          exp_valid;
        logic [WW-1:0] exp_word;
    } slot_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_held();
        check("word", 32'(word), 32'(m_word));
        check("word_ch", 32'(word_ch), 32'(m_ch));
        check("vol", 32'(vol), 32'(m_word % (1 << VW)));
    endtask

    task automatic model_reset();
        m_word   = '0;
        m_ch     = 1'b0;
        cur_ws   = 1'b0;
        prev_len = WW;
    endtask

    // Drive one ws slot and check every cycle of it.
    task automatic drive_slot(input logic ws, input int len, input logic [WW-1:0] d,
                              input logic junk, input logic exp_err, input logic exp_valid,
                              input logic [WW-1:0] exp_word);
        for (int i = 0; i < len; i++) begin
            audio_ws   = ws;
            audio_data = (i < WW) ? d[WW-1-i] : junk;
            @(posedge clk_audio_bit);
            #1;
            check("frame_err", 32'(frame_err), 32'((i == 0) && exp_err));
            check("word_valid", 32'(word_valid), 32'((i == WW-1) && exp_valid));
            if (i == WW-1 && exp_valid) begin
                m_word = exp_word;
                m_ch   = ws;
            end
            check_held();
        end
        cur_ws   = ws;
        prev_len = len;
    endtask

    // Slot generated from the framing rules alone.
    task automatic rule_slot(input int len, input logic [WW-1:0] d, input logic junk);
        logic ws;
        ws = ~cur_ws;
        drive_slot(ws, len, d, junk, prev_len < WW, len >= WW, d);
    endtask

    task automatic drive_idle(input logic ws, input logic data, input int n);
        for (int i = 0; i < n; i++) begin
            audio_ws   = ws;
            audio_data = data;
            @(posedge clk_audio_bit);
            #1;
            check("idle_frame_err", 32'(frame_err), 32'(0));
            check("idle_word_valid", 32'(word_valid), 32'(0));
            check_held();
        end
        cur_ws = ws;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_word", 32'(word), 32'(0));
        check("rst_word_ch", 32'(word_ch), 32'(0));
        check("rst_valid", 32'(word_valid), 32'(0));
        check("rst_vol", 32'(vol), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        reset_n = 1'b1;
    endtask

    slot_t tbl[7];

    initial begin
        model_reset();
        tbl[0] = '{1'b1, 8,  8'h3F, 1'b0, 1'b0, 1'b1, 8'h3F};
        tbl[1] = '{1'b0, 8,  8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2] = '{1'b1, 8,  8'h2A, 1'b0, 1'b0, 1'b1, 8'h2A};
        tbl[3] = '{1'b0, 5,  8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b1, 8,  8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 12, 8'h81, 1'b1, 1'b0, 1'b1, 8'h81};
        tbl[6] = '{1'b1, 8,  8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};

        // Reset state
        repeat (2) @(posedge clk_audio_bit);
        #1;
        check("reset_word", 32'(word), 32'(0));
        check("reset_word_ch", 32'(word_ch), 32'(0));
        check("reset_valid", 32'(word_valid), 32'(0));
        check("reset_vol", 32'(vol), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        @(negedge clk_audio_bit);
        reset_n = 1'b1;
        @(posedge clk_audio_bit);
        #1;

        // Table: basic words, short word, wide slot
        for (int k = 0; k < 7; k++)
            drive_slot(tbl[k].ws, tbl[k].len, tbl[k].d, tbl[k].junk,
                       tbl[k].exp_err, tbl[k].exp_valid, tbl[k].exp_word);

        // ws held low with data=1: nothing until the first toggle
        async_reset();
        drive_idle(1'b0, 1'b1, 20);
        drive_slot(1'b1, 8, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3);

        // Reset in the middle of a word: that word is dropped
        drive_slot(1'b0, 4, 8'hE7, 1'b0, 1'b0, 1'b0, 8'h00);
        async_reset();
        drive_idle(1'b0, 1'b1, 4);
        drive_slot(1'b1, 8, 8'h99, 1'b0, 1'b0, 1'b1, 8'h99);

        // Encoder-style continuous frames sweeping vol 0..63
        for (int v = 0; v < 64; v++)
            rule_slot(WW, 8'(v), 1'b0);

        // Random slot lengths and contents
        for (int n = 0; n < 200; n++)
            rule_slot(int'($urandom_range(3, 12)), 8'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
